// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a 2^FIFO_AW-byte FIFO through a valid/ready handshake.
module uart_tx_fifo #(
  parameter int TIMER_BITS      = 10,
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int FIFO_AW         = 4
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [7:0]         i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_busy,
  output logic [FIFO_AW:0]   o_count
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [TIMER_BITS-1:0] RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic [TIMER_BITS-1:0] cnt, cnt_n;
  logic tx_n, push, pop, tick, has;
  assign o_ready = o_count != (FIFO_AW+1)'(DEPTH);
  assign push    = i_valid && o_ready;
  assign o_busy  = state != IDLE;
  assign tick    = cnt == '0;
  assign has     = o_count != '0;
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    cnt_n   = (state == IDLE) ? cnt : cnt - 1'b1;
    tx_n    = o_tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (has) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          cnt_n   = RELOAD;
          state_n = START;
        end
      end
      START: if (tick) begin
        tx_n    = shift[0];
        idx_n   = '0;
        cnt_n   = RELOAD;
        state_n = DATA;
      end
      DATA: if (tick) begin
        cnt_n = RELOAD;
        if (idx == 3'd7) begin
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          shift_n = shift >> 1;
          tx_n    = shift[1];
          idx_n   = idx + 3'd1;
        end
      end
      STOP: if (tick) begin
        if (has) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          cnt_n   = RELOAD;
          state_n = START;
        end else begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state   <= IDLE;
      shift   <= '0;
      idx     <= '0;
      cnt     <= '0;
      o_tx    <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      o_tx    <= tx_n;
      wr_ptr  <= wr_ptr + FIFO_AW'(push);
      rd_ptr  <= rd_ptr + FIFO_AW'(pop);
      o_count <= o_count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= i_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a line decoder pops expected bytes and checks every bit width.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  logic clk = 0, i_reset = 1;
  logic [7:0] i_data = 0, i_data_s = 0;
  logic i_valid = 0, i_valid_s = 0;
  logic ready, tx, busy, ready_s, tx_s, busy_s;
  logic [4:0] count, count_s;
  logic [7:0] sb [$];
  int checks = 0, errors = 0, busy_cyc = 0, falls = 0, rst_edges = 0;
  logic prev_busy = 0;
  always #5 clk = ~clk;
  uart_tx_fifo #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_count(count));
  uart_tx_fifo dut_s (
    .clk(clk), .i_reset(i_reset), .i_data(i_data_s), .i_valid(i_valid_s),
    .o_ready(ready_s), .o_tx(tx_s), .o_busy(busy_s), .o_count(count_s));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic get_frame(input int cpb, input bit slow, output logic [7:0] b, output bit bad);
    logic [9:0] bv;
    logic v;
    bad = 0;
    bv = '0;
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < cpb; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        v = slow ? tx_s : tx;
        if (c == 0) bv[i] = v;
        else if (v !== bv[i]) bad = 1;
      end
    if (bv[0] !== 1'b0 || bv[9] !== 1'b1) bad = 1;
    b = bv[8:1];
  endtask
  task automatic wr(input logic [7:0] d);
    i_valid = 1;
    i_data = d;
    @(negedge clk);
    i_valid = 0;
  endtask
  task automatic wait_idle(input int n);
    bit done = 0;
    for (int t = 0; t < n && !done; t++) begin
      @(negedge clk);
      if (!busy && count == 0) done = 1;
    end
    check("idle_timeout", done, 1);
    repeat (2) @(negedge clk);
  endtask
  always @(posedge clk) if (i_reset) rst_edges++;
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (prev_busy && !busy) falls++;
    prev_busy = busy;
  end
  always begin : monitor
    logic [7:0] b;
    bit bad;
    int r0;
    @(negedge clk);
    if (tx === 1'b0 && !i_reset) begin
      r0 = rst_edges;
      get_frame(CPB, 0, b, bad);
      if (r0 == rst_edges) begin
        check("frame_shape", bad, 0);
        if (sb.size() == 0) check("unexpected_frame", b, 32'hFFFF_FFFF);
        else check("byte", b, sb.pop_front());
      end
    end
  end
  initial begin
    #5ms;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b;
    bit bad;
    int t;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    check("rst_count", count, 0);
    i_reset = 0;
    @(negedge clk);
    busy_cyc = 0; falls = 0;
    sb.push_back(8'h55);
    wr(8'h55);
    check("k_count", count, 1);
    check("k_tx", tx, 1);
    @(negedge clk);
    check("k1_tx", tx, 0);
    check("k1_count", count, 0);
    check("k1_busy", busy, 1);
    wait_idle(200);
    check("busy_40", busy_cyc, 40);
    check("falls_55", falls, 1);
    busy_cyc = 0; falls = 0;
    sb.push_back(8'h00); sb.push_back(8'hFF);
    i_valid = 1; i_data = 8'h00;
    @(negedge clk);
    i_data = 8'hFF;
    @(negedge clk);
    i_valid = 0;
    wait_idle(300);
    check("busy_80", busy_cyc, 80);
    check("falls_b2b", falls, 1);
    sb.push_back(8'hAA);
    wr(8'hAA);
    i_valid = 1;
    for (int i = 1; i <= 17; i++) begin
      i_data = 8'(i);
      if (i <= 16) sb.push_back(8'(i));
      @(negedge clk);
    end
    check("full_count", count, 16);
    check("full_ready", ready, 0);
    i_data = 8'h77;
    t = 0;
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("ready_rise_to", t < 100, 1);
    check("ready_rise_tx", tx, 0);
    check("ready_rise_count", count, 15);
    sb.push_back(8'h77);
    @(negedge clk);
    i_valid = 0;
    check("refill_count", count, 16);
    check("refill_ready", ready, 0);
    wait_idle(2000);
    for (int n = 0; n < 40; n++) begin
      t = 0;
      while (!ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) check("stream_ready_to", 0, 1);
      b = 8'($urandom);
      sb.push_back(b);
      wr(b);
    end
    wait_idle(3000);
    check("sb_after_stream", sb.size(), 0);
    wr(8'hA5); wr(8'h11); wr(8'h22); wr(8'h33);
    repeat (6) @(negedge clk);
    check("mid_busy", busy, 1);
    i_reset = 1;
    @(negedge clk);
    i_reset = 0;
    check("mr_tx", tx, 1);
    check("mr_busy", busy, 0);
    check("mr_count", count, 0);
    check("mr_ready", ready, 1);
    busy_cyc = 0;
    repeat (100) @(negedge clk);
    check("mr_no_frames", busy_cyc, 0);
    sb.push_back(8'h3C);
    wr(8'h3C);
    wait_idle(200);
    check("sb_after_reset", sb.size(), 0);
    i_valid_s = 1; i_data_s = 8'h41;
    @(negedge clk);
    i_valid_s = 0;
    t = 0;
    while (tx_s !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("slow_start_to", t < 10, 1);
    get_frame(868, 1, b, bad);
    check("slow_byte", b, 8'h41);
    check("slow_shape", bad, 0);
    repeat (3) @(negedge clk);
    check("slow_idle", busy_s, 0);
    check("sb_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
